// File: rtl/mcore_bit_unpacker.sv
// MSB-first bit unpacker: buffers 32-bit stream words and serves read/skip
// commands of arbitrary bit width, one completion pulse per accepted command.
module mcore_bit_unpacker #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                                    aclk,
   input  logic                                    rsta,
   input  logic [DATA_WIDTH-1:0]                   s_word_data,
   input  logic                                    s_word_valid,
   output logic                                    s_word_ready,
   input  logic                                    flush,
   input  logic                                    cmd_valid,
   output logic                                    cmd_ready,
   input  logic [1:0]                              cmd_op,
   input  logic [7:0]                              cmd_width,
   output logic                                    rsp_valid,
   output logic [DATA_WIDTH-1:0]                   rsp_data,
   output logic                                    busy,
   output logic [1:0]                              state_dbg,
   output logic [$clog2(2*DATA_WIDTH+1)-1:0]       fill_dbg
);

   localparam int BUF_W  = 2 * DATA_WIDTH;
   localparam int FILL_W = $clog2(BUF_W + 1);
   localparam int WID_W  = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      SKIP      = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t              state, next_state;
   logic [BUF_W-1:0]    buf_q, buf_next;
   logic [FILL_W-1:0]   fill_q, fill_after, fill_next;
   logic [FILL_W-1:0]   consumed;
   logic [7:0]          remaining_q;
   logic [7:0]          skip_take;
   logic [WID_W-1:0]    width_q, width_sat;
   logic [DATA_WIDTH-1:0] read_value;
   logic                cmd_accept, word_take, read_fire, load_zero;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends on the matching valid, so no comb loops.
   assign cmd_ready    = (state == IDLE) && !flush && !rsta;
   assign cmd_accept   = cmd_valid && cmd_ready;
   assign rsp_valid    = (state == DONE) && !flush;
   assign busy         = (state != IDLE);
   assign state_dbg    = state;
   assign fill_dbg     = fill_q;

   assign width_sat  = (cmd_width > 8'(DATA_WIDTH)) ? WID_W'(DATA_WIDTH)
                                                     : cmd_width[WID_W-1:0];
   assign skip_take  = (8'(fill_q) < remaining_q) ? 8'(fill_q) : remaining_q;
   // Top DATA_WIDTH bits, right-aligned to the requested width; width 0 gives 0.
   assign read_value = buf_q[BUF_W-1 -: DATA_WIDTH] >> (WID_W'(DATA_WIDTH) - width_q);

   always_comb begin
      next_state = state;
      consumed   = '0;
      read_fire  = 1'b0;
      load_zero  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_accept) begin
               case (cmd_op)
                  2'd2:    next_state = READ_WAIT;
                  2'd1:    next_state = SKIP;
                  default: begin
                     next_state = DONE;
                     load_zero  = 1'b1;
                  end
               endcase
            end
         end
         READ_WAIT: begin
            if (fill_q >= FILL_W'(width_q)) begin
               consumed   = FILL_W'(width_q);
               read_fire  = 1'b1;
               next_state = DONE;
            end
         end
         SKIP: begin
            consumed = FILL_W'(skip_take);
            if (remaining_q == skip_take) begin
               next_state = DONE;
               load_zero  = 1'b1;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   // The incoming word lands directly below whatever survives this cycle's consumption.
   always_comb begin
      fill_after   = fill_q - consumed;
      s_word_ready = (fill_after <= FILL_W'(DATA_WIDTH)) && !flush && !rsta;
      word_take    = s_word_valid && s_word_ready;
      buf_next     = buf_q << consumed;
      fill_next    = fill_after;
      if (word_take) begin
         buf_next  = buf_next | ({s_word_data, {DATA_WIDTH{1'b0}}} >> fill_after);
         fill_next = fill_after + FILL_W'(DATA_WIDTH);
      end
   end

   always_ff @(posedge aclk or posedge rsta) begin
      if (rsta) begin
         state       <= IDLE;
         buf_q       <= '0;
         fill_q      <= '0;
         remaining_q <= '0;
         width_q     <= '0;
         rsp_data    <= '0;
      end else if (flush) begin
         state       <= IDLE;
         buf_q       <= '0;
         fill_q      <= '0;
         remaining_q <= '0;
      end else begin
         state  <= next_state;
         buf_q  <= buf_next;
         fill_q <= fill_next;
         if (cmd_accept) begin
            width_q     <= width_sat;
            remaining_q <= cmd_width;
         end else if (state == SKIP) begin
            remaining_q <= remaining_q - skip_take;
         end
         if (read_fire) rsp_data <= read_value;
         else if (load_zero) rsp_data <= '0;
      end
   end

endmodule

// File: tb/tb_mcore_bit_unpacker.sv
// Bench for mcore_bit_unpacker: table of commands over a fixed word stream,
// directed multi-cycle corner sequences, and a randomized bit-queue model.
module tb_mcore_bit_unpacker;

   localparam logic [1:0] ST_IDLE = 2'd0, ST_READ_WAIT = 2'd1, ST_SKIP = 2'd2;

   logic        aclk = 1'b0;
   logic        rsta;
   logic [31:0] s_word_data;
   logic        s_word_valid;
   logic        s_word_ready;
   logic        flush;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_width;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        busy;
   logic [1:0]  state_dbg;
   logic [6:0]  fill_dbg;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] word_q[$];
   bit          model_bits[$];
   logic [31:0] mon_exp;
   bit          finished = 0;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  width;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[9];

   mcore_bit_unpacker #(.DATA_WIDTH(32)) dut (
      .aclk(aclk), .rsta(rsta),
      .s_word_data(s_word_data), .s_word_valid(s_word_valid), .s_word_ready(s_word_ready),
      .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_width(cmd_width),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .state_dbg(state_dbg), .fill_dbg(fill_dbg)
   );

   // clock / reset
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // scoreboard: every rsp_valid must match the oldest expected result
   always @(negedge aclk) begin
      if (!rsta && rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=%h required=no_response t=%0t", rsp_data, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("rsp_data", rsp_data, mon_exp);
         end
      end
   end

   // word driver
   initial begin
      s_word_valid = 1'b0;
      s_word_data  = '0;
      forever begin
         if (word_q.size() == 0 || rsta) begin
            s_word_valid = 1'b0;
            @(posedge aclk); #1;
         end else begin
            s_word_valid = 1'b1;
            s_word_data  = word_q[0];
            @(negedge aclk);
            if (s_word_ready) begin
               @(posedge aclk); #1;
               word_q.delete(0);
               s_word_valid = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  @(posedge aclk); #1;
               end
            end else begin
               @(posedge aclk); #1;
            end
         end
      end
   end

   task automatic push_word(input logic [31:0] w);
      word_q.push_back(w);
      for (int i = 31; i >= 0; i--) model_bits.push_back(w[i]);
   endtask

   function automatic logic [31:0] take_bits(input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = {v[30:0], model_bits.pop_front()};
      return v;
   endfunction

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] w,
                           input logic [31:0] req, input bit expect_rsp);
      int n = 0;
      @(posedge aclk); #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_width = w;
      do begin
         @(negedge aclk);
         n++;
      end while (!cmd_ready && n < 3000);
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL cmd_accept_timeout actual=not_ready required=ready t=%0t", $time);
         cmd_valid = 1'b0;
         return;
      end
      if (expect_rsp) exp_q.push_back(req);
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL %s_timeout actual=busy required=idle pending=%0d", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_fill(input logic [6:0] v);
      int n = 0;
      while (fill_dbg !== v && n < 200) begin
         @(negedge aclk);
         n++;
      end
      chk("fill_reach", {25'd0, fill_dbg}, {25'd0, v});
   endtask

   task automatic flush_pulse();
      int n = 0;
      while ((word_q.size() != 0 || s_word_valid) && n < 500) begin
         @(negedge aclk);
         n++;
      end
      @(posedge aclk); #1;
      flush = 1'b1;
      @(posedge aclk); #1;
      flush = 1'b0;
      model_bits.delete();
   endtask

   initial begin
      #500000;
      if (!finished) begin
         checks++;
         failures++;
         $display("FAIL global_timeout actual=running required=finished");
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      rsta = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_width = '0;
      tbl[0] = '{2'd2, 8'd8,   32'h02};
      tbl[1] = '{2'd2, 8'd8,   32'h40};
      tbl[2] = '{2'd2, 8'd6,   32'h27};
      tbl[3] = '{2'd2, 8'd8,   32'he5};
      tbl[4] = '{2'd2, 8'd6,   32'h2a};
      tbl[5] = '{2'd0, 8'd5,   32'h0};
      tbl[6] = '{2'd3, 8'd200, 32'h0};
      tbl[7] = '{2'd2, 8'd0,   32'h0};
      tbl[8] = '{2'd2, 8'd28,  32'h047aebaa};

      // reset state
      #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_word_ready", {31'd0, s_word_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_fill", {25'd0, fill_dbg}, 32'd0);
      repeat (3) @(posedge aclk);
      #1 rsta = 1'b0;
      @(negedge aclk);
      chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rel_word_ready", {31'd0, s_word_ready}, 32'd1);

      // table: fixed two-word stream
      push_word(32'h02409f96);
      push_word(32'ha47aebaa);
      for (int i = 0; i < 9; i++) send_cmd(tbl[i].op, tbl[i].width, tbl[i].exp, 1'b1);
      wait_done("table");
      chk("table_fill", {25'd0, fill_dbg}, 32'd0);

      // read latency with bits already buffered
      flush_pulse();
      push_word(32'hc3000000);
      wait_fill(7'd32);
      send_cmd(2'd2, 8'd8, 32'hc3, 1'b1);
      @(negedge aclk);
      chk("lat_first_cycle", {31'd0, rsp_valid}, 32'd0);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      @(negedge aclk);
      chk("lat_second_cycle", {31'd0, rsp_valid}, 32'd1);
      wait_done("latency");

      // read stalls until a word arrives
      flush_pulse();
      send_cmd(2'd2, 8'd8, 32'hff, 1'b1);
      repeat (20) @(negedge aclk);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_state", {30'd0, state_dbg}, {30'd0, ST_READ_WAIT});
      word_q.push_back(32'hff000000);
      wait_done("stall_read");

      // skip, read across words, long skip stalling for a later word
      flush_pulse();
      push_word(32'h0000000f);
      push_word(32'h80000000);
      send_cmd(2'd1, 8'd28, 32'h0, 1'b1);
      send_cmd(2'd2, 8'd5, 32'h1f, 1'b1);
      send_cmd(2'd1, 8'd60, 32'h0, 1'b1);
      repeat (6) @(negedge aclk);
      chk("skip_stall_state", {30'd0, state_dbg}, {30'd0, ST_SKIP});
      push_word(32'h0000000a);
      send_cmd(2'd2, 8'd3, 32'h2, 1'b1);
      wait_done("skip");

      // saturating read width
      flush_pulse();
      push_word(32'h12345678);
      push_word(32'habcd0000);
      wait_fill(7'd64);
      send_cmd(2'd2, 8'd40, 32'h12345678, 1'b1);
      wait_done("wide_read");
      chk("wide_fill", {25'd0, fill_dbg}, 32'd32);
      send_cmd(2'd2, 8'd16, 32'habcd, 1'b1);
      wait_done("wide_tail");
      chk("tail_fill", {25'd0, fill_dbg}, 32'd16);

      // flush during READ_WAIT
      flush_pulse();
      send_cmd(2'd2, 8'd8, 32'h0, 1'b0);
      repeat (3) @(negedge aclk);
      chk("fl_state_before", {30'd0, state_dbg}, {30'd0, ST_READ_WAIT});
      @(posedge aclk); #1 flush = 1'b1;
      @(negedge aclk);
      chk("fl_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("fl_word_ready", {31'd0, s_word_ready}, 32'd0);
      @(posedge aclk); #1 flush = 1'b0;
      @(negedge aclk);
      chk("fl_busy", {31'd0, busy}, 32'd0);
      chk("fl_fill", {25'd0, fill_dbg}, 32'd0);
      repeat (5) @(negedge aclk);
      push_word(32'ha5000000);
      send_cmd(2'd2, 8'd8, 32'ha5, 1'b1);
      wait_done("after_flush");

      // reset in the middle of a skip
      flush_pulse();
      send_cmd(2'd1, 8'd100, 32'h0, 1'b0);
      repeat (3) @(negedge aclk);
      chk("rs_state_before", {30'd0, state_dbg}, {30'd0, ST_SKIP});
      @(posedge aclk); #1 rsta = 1'b1;
      #1;
      chk("rs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd0);
      chk("rs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rs_word_ready", {31'd0, s_word_ready}, 32'd0);
      chk("rs_rsp_data", rsp_data, 32'd0);
      chk("rs_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      repeat (2) @(posedge aclk);
      #1 rsta = 1'b0;
      model_bits.delete();
      @(negedge aclk);
      chk("rs_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rs_rel_word_ready", {31'd0, s_word_ready}, 32'd1);
      push_word(32'h3c000000);
      send_cmd(2'd2, 8'd8, 32'h3c, 1'b1);
      wait_done("after_reset");

      // randomized commands against a bit-queue model
      flush_pulse();
      for (int it = 0; it < 40; it++) begin
         int r = $urandom_range(0, 9);
         int w;
         int need;
         logic [1:0] op;
         logic [31:0] req;
         if (r < 5) begin
            op = 2'd2; w = $urandom_range(0, 40); need = (w > 32) ? 32 : w;
         end else if (r < 9) begin
            op = 2'd1; w = $urandom_range(0, 255); need = w;
         end else begin
            op = (r[0]) ? 2'd3 : 2'd0; w = $urandom_range(0, 255); need = 0;
         end
         while (model_bits.size() < need) push_word($urandom());
         req = (op == 2'd2) ? take_bits(need) : 32'h0;
         if (op == 2'd1) for (int k = 0; k < need; k++) model_bits.delete(0);
         send_cmd(op, 8'(w), req, 1'b1);
      end
      wait_done("random");
      chk("random_fill", {25'd0, fill_dbg}, 32'(model_bits.size()));
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      finished = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
